// File: rtl/mandel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mandel_scheduler_if
// Description : Bundles the frame-request inputs, the shared iterator-core
//               job/result bus and the pixel-store write port of the
//               Mandelbrot pixel scheduler.
//               master = scheduler side, slave = environment side.
// Revision    : 1.0  initial release
// ============================================================================
interface mandel_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int COORD_W   = 27,
    parameter int ITER_W    = 16,
    parameter int ADDR_W    = 19
);
    // Frame request
    logic                          start;
    logic signed [COORD_W-1:0]     cr_initial;
    logic signed [COORD_W-1:0]     ci_initial;
    logic signed [COORD_W-1:0]     step_r;
    logic signed [COORD_W-1:0]     step_i;
    logic [ITER_W-1:0]             max_iterations;
    // Iterator-core job / result bus
    logic [NUM_CORES-1:0]          core_start;
    logic signed [COORD_W-1:0]     core_cr;
    logic signed [COORD_W-1:0]     core_ci;
    logic [ITER_W-1:0]             core_max_iter;
    logic [NUM_CORES-1:0]          core_done;
    logic [NUM_CORES*ITER_W-1:0]   core_iter;
    logic [NUM_CORES-1:0]          core_ack;
    // Pixel store write port and status
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [ITER_W-1:0]             wr_data;
    logic                          busy;
    logic [31:0]                   finish_render;
    logic                          frame_done;

    modport master (
        input  start, cr_initial, ci_initial, step_r, step_i, max_iterations,
        input  core_done, core_iter,
        output core_start, core_cr, core_ci, core_max_iter, core_ack,
        output wr_en, wr_addr, wr_data, busy, finish_render, frame_done
    );

    modport slave (
        output start, cr_initial, ci_initial, step_r, step_i, max_iterations,
        output core_done, core_iter,
        input  core_start, core_cr, core_ci, core_max_iter, core_ack,
        input  wr_en, wr_addr, wr_data, busy, finish_render, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/mandel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mandel_scheduler
// Description : Walks the frame in raster order handing one pixel per cycle
//               to the lowest-index idle iterator core, and retires one core
//               result per cycle into the pixel store (clamped to the
//               iteration ceiling). All outputs are registered, so a decision
//               taken on an edge is visible for the following cycle.
//               finish_render reports the number of busy cycles that preceded
//               the DONE cycle.
// Revision    : 1.0  initial release
// ============================================================================
module mandel_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int COORD_W   = 27,
    parameter int ITER_W    = 16,
    parameter int ADDR_W    = 19
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    mandel_scheduler_if.master bus
);

    localparam int c_X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int c_Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(H_RES - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(V_RES - 1);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_DISPATCH = 2'd1;
    localparam logic [1:0] c_S_DRAIN    = 2'd2;
    localparam logic [1:0] c_S_DONE     = 2'd3;

    logic [1:0]                r_state;
    logic                      r_busy;
    logic [31:0]               r_cycle_cnt;
    logic [31:0]               r_finish;
    logic                      r_frame_done;

    // Frame parameters captured at start
    logic signed [COORD_W-1:0] r_cr0;
    logic signed [COORD_W-1:0] r_step_r;
    logic signed [COORD_W-1:0] r_step_i;
    logic [ITER_W-1:0]         r_max_iter;

    // Raster walk position
    logic [c_X_W-1:0]          r_x;
    logic [c_Y_W-1:0]          r_y;
    logic [ADDR_W-1:0]         r_addr;
    logic signed [COORD_W-1:0] r_cur_cr;
    logic signed [COORD_W-1:0] r_cur_ci;

    // Core bookkeeping and registered outputs
    logic [NUM_CORES-1:0]      r_core_busy;
    logic [ADDR_W-1:0]         r_pix_addr [NUM_CORES];
    logic [NUM_CORES-1:0]      r_core_start;
    logic [NUM_CORES-1:0]      r_core_ack;
    logic signed [COORD_W-1:0] r_core_cr;
    logic signed [COORD_W-1:0] r_core_ci;
    logic                      r_wr_en;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [ITER_W-1:0]         r_wr_data;

    logic                      w_disp_hit;
    logic [c_IDX_W-1:0]        w_disp_idx;
    logic [NUM_CORES-1:0]      w_disp_mask;
    logic                      w_ret_hit;
    logic [c_IDX_W-1:0]        w_ret_idx;
    logic [NUM_CORES-1:0]      w_ret_mask;
    logic [ITER_W-1:0]         w_ret_iter;
    logic [ITER_W-1:0]         w_ret_data;
    logic [31:0]               w_cnt_inc;

    // Lowest-index idle core (dispatch) and lowest-index finished busy core (retire)
    always_comb begin
        w_disp_hit  = 1'b0;
        w_disp_idx  = '0;
        w_disp_mask = '0;
        w_ret_hit   = 1'b0;
        w_ret_idx   = '0;
        w_ret_mask  = '0;
        w_ret_iter  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!r_core_busy[i]) begin
                w_disp_hit  = 1'b1;
                w_disp_idx  = c_IDX_W'(i);
                w_disp_mask = '0;
                w_disp_mask[i] = 1'b1;
            end
            if (bus.core_done[i] && r_core_busy[i]) begin
                w_ret_hit  = 1'b1;
                w_ret_idx  = c_IDX_W'(i);
                w_ret_mask = '0;
                w_ret_mask[i] = 1'b1;
                w_ret_iter = bus.core_iter[i*ITER_W +: ITER_W];
            end
        end
        if (!(w_disp_hit && (r_state == c_S_DISPATCH))) begin
            w_disp_mask = '0;
        end
        w_ret_data = (w_ret_iter > r_max_iter) ? r_max_iter : w_ret_iter;
        w_cnt_inc  = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 32'd1;
    end

    // Frame state machine, raster walk, core tracking and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_S_IDLE;
            r_busy       <= 1'b0;
            r_cycle_cnt  <= '0;
            r_finish     <= '0;
            r_frame_done <= 1'b0;
            r_cr0        <= '0;
            r_step_r     <= '0;
            r_step_i     <= '0;
            r_max_iter   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_cur_cr     <= '0;
            r_cur_ci     <= '0;
            r_core_busy  <= '0;
            r_core_start <= '0;
            r_core_ack   <= '0;
            r_core_cr    <= '0;
            r_core_ci    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_pix_addr[i] <= '0;
            end
        end else begin
            r_core_start <= '0;
            r_core_ack   <= '0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            if (r_busy) begin
                r_cycle_cnt <= w_cnt_inc;
            end

            // A retired core is cleared here and only seen as free next cycle
            if (w_ret_hit) begin
                r_core_ack <= w_ret_mask;
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_pix_addr[w_ret_idx];
                r_wr_data  <= w_ret_data;
            end
            r_core_busy <= (r_core_busy & ~w_ret_mask) | w_disp_mask;

            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_cr0       <= bus.cr_initial;
                        r_step_r    <= bus.step_r;
                        r_step_i    <= bus.step_i;
                        r_max_iter  <= bus.max_iterations;
                        r_cur_cr    <= bus.cr_initial;
                        r_cur_ci    <= bus.ci_initial;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_addr      <= '0;
                        r_cycle_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= c_S_DISPATCH;
                    end
                end
                c_S_DISPATCH: begin
                    if (w_disp_hit) begin
                        r_core_start           <= w_disp_mask;
                        r_core_cr              <= r_cur_cr;
                        r_core_ci              <= r_cur_ci;
                        r_pix_addr[w_disp_idx] <= r_addr;
                        r_addr                 <= r_addr + 1'b1;
                        if (r_x == c_X_LAST) begin
                            r_x      <= '0;
                            r_y      <= r_y + 1'b1;
                            r_cur_cr <= r_cr0;
                            r_cur_ci <= r_cur_ci + r_step_i;
                            if (r_y == c_Y_LAST) begin
                                r_state <= c_S_DRAIN;
                            end
                        end else begin
                            r_x      <= r_x + 1'b1;
                            r_cur_cr <= r_cur_cr + r_step_r;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (r_core_busy == '0) begin
                        r_frame_done <= 1'b1;
                        r_finish     <= w_cnt_inc;
                        r_state      <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_start    = r_core_start;
    assign bus.core_cr       = r_core_cr;
    assign bus.core_ci       = r_core_ci;
    assign bus.core_max_iter = r_max_iter;
    assign bus.core_ack      = r_core_ack;
    assign bus.wr_en         = r_wr_en;
    assign bus.wr_addr       = r_wr_addr;
    assign bus.wr_data       = r_wr_data;
    assign bus.busy          = r_busy;
    assign bus.finish_render = r_finish;
    assign bus.frame_done    = r_frame_done;

endmodule
`default_nettype wire
